mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters: IF-stage instruction fetch and MWB-stage load/store.
- Sequences each memory transaction through a fixed read latency.
- Drives a pipeline stall while any requester is waiting, so the forwarding/hazard logic only ever sees completed results.
- Data requests get priority (older instruction). A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter_pkg.sv | 40 ++++
 rtl/mem_port_arbiter_starve.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Purpose:
//    Shared types and constants for the unified memory port arbiter. The
//    arbiter and its starvation counter both import this package so that the
//    grant and state encodings stay in one place.
//
// Contents:
//    state_t   : arbiter FSM state (IDLE, BUSY)
//    gnt_t     : latched grant owner (GNT_FETCH, GNT_DATA)
//    WE_NONE   : byte write mask used for reads and idle cycles
//    CNT_W     : width of the latency down-counter (MEM_LAT up to 4)
//    STARVE_W  : width of the starvation counter (STARVE_MAX up to 15)
//    lat_load  : value loaded into the latency counter at issue
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } gnt_t;

   localparam logic [3:0] WE_NONE = 4'b0000;

   localparam int CNT_W    = 2;
   localparam int STARVE_W = 4;

   // The counter is loaded with MEM_LAT-1 so that it reaches zero in the
   // cycle exactly MEM_LAT cycles after the issue cycle.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
//
// Purpose:
//    Counts consecutive data grants issued while a fetch is waiting. Once the
//    count reaches STARVE_MAX the force_fetch flag tells the arbiter to hand
//    the next contested grant to the fetch side, guaranteeing that the
//    instruction stream makes progress under a continuous load/store burst.
//
// Ports:
//    clk          in   system clock, rising edge
//    rst          in   asynchronous active-high reset
//    if_req       in   fetch request level; low clears the count
//    grant_fetch  in   one-cycle strobe, a fetch was issued this cycle
//    grant_data   in   one-cycle strobe, a data access was issued this cycle
//    force_fetch  out  count has reached STARVE_MAX
// ---------------------------------------------------------------------------
module arb_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic grant_fetch,
   input  logic grant_data,
   output logic force_fetch
);

   localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt;

   // The count only means something while a fetch is actually waiting, so it
   // is dropped whenever if_req is low as well as when the fetch finally wins.
   // It saturates at MAX_CNT instead of wrapping so force_fetch stays set
   // until a fetch grant clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!if_req || grant_fetch) begin
         starve_cnt <= '0;
      end else if (grant_data && (starve_cnt != MAX_CNT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign force_fetch = (starve_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//    Shares the single unified instruction/data memory port between the IF
//    stage (instruction fetch) and the MWB stage (load/store). Each access is
//    issued in one IDLE cycle and completes exactly MEM_LAT cycles later, when
//    the owner's valid pulses for one cycle with the read data routed through.
//    Data accesses win contested cycles because they belong to the older
//    instruction; arb_starve_ctr forces a fetch after STARVE_MAX consecutive
//    data wins. stall is asserted while either requester is still waiting.
//
// Parameters:
//    MEM_LAT     memory read latency in cycles, 1..4
//    STARVE_MAX  data grants allowed while a fetch waits, 1..15
//
// Ports:
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-high reset
//    if_req     in   fetch request, held until if_valid
//    if_addr    in   fetch byte address
//    if_rdata   out  fetch data, valid with if_valid (0 otherwise)
//    if_valid   out  one-cycle fetch completion pulse
//    d_req      in   load/store request, held until d_valid
//    d_we       in   byte write mask, 0 = load
//    d_addr     in   data byte address
//    d_wdata    in   store data
//    d_rdata    out  load data, valid with d_valid (0 otherwise)
//    d_valid    out  one-cycle data completion pulse
//    mem_en     out  memory command strobe (issue cycle only)
//    mem_we     out  memory byte write mask (issue cycle only)
//    mem_addr   out  memory address
//    mem_wdata  out  memory write data
//    mem_rdata  in   memory read data, MEM_LAT cycles after mem_en
//    stall      out  pipeline hold request
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall
);

   localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state;
   gnt_t              gnt;
   logic [CNT_W-1:0]  cnt;

   logic              any_req;
   logic              force_fetch;
   logic              win_data;
   logic              issue;
   logic              grant_fetch;
   logic              grant_data;

   // Winner selection. Data wins any contested cycle unless the starvation
   // counter has saturated, in which case the waiting fetch goes first.
   assign any_req  = if_req | d_req;
   assign win_data = d_req & ~(if_req & force_fetch);

   // An access is issued only from IDLE. rst is folded in so that a request
   // held high during reset cannot put a command on the port.
   assign issue       = (state == IDLE) & any_req & ~rst;
   assign grant_data  = issue & win_data;
   assign grant_fetch = issue & ~win_data;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .grant_fetch (grant_fetch),
      .grant_data  (grant_data),
      .force_fetch (force_fetch)
   );

   // Memory command path. The command goes out combinationally in the issue
   // cycle so the access starts without an extra register stage. The write
   // mask is forced to WE_NONE outside the issue cycle so a store is written
   // exactly once even though d_we stays asserted until d_valid.
   always_comb begin
      mem_en    = issue;
      mem_we    = WE_NONE;
      mem_addr  = if_addr;
      mem_wdata = '0;
      if (win_data) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         if (issue) begin
            mem_we = d_we;
         end
      end
   end

   // Sequencing FSM. The valid pulses are registered: they are set on the
   // edge that enters the completion cycle (cnt reaching 0), which for
   // MEM_LAT=1 is the issue edge itself. Completion always returns to IDLE,
   // so a new grant is never evaluated in a completion cycle and a requester
   // that keeps req high is simply re-arbitrated in the next IDLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= GNT_FETCH;
         cnt      <= '0;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt   <= win_data ? GNT_DATA : GNT_FETCH;
                  cnt   <= LAT_LOAD;
                  state <= BUSY;
                  if (MEM_LAT == 1) begin
                     if_valid <= ~win_data;
                     d_valid  <= win_data;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_ONE) begin
                     if_valid <= (gnt == GNT_FETCH);
                     d_valid  <= (gnt == GNT_DATA);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read data is only meaningful in the completion cycle, where mem_rdata
   // arrives from the memory; outside it the data outputs read as zero.
   assign if_rdata = if_valid ? mem_rdata : '0;
   assign d_rdata  = d_valid  ? mem_rdata : '0;

   // Hold the pipeline while either requester is still waiting for its
   // result; the valid term releases a requester in its completion cycle.
   assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Main DUT (MEM_LAT=1, STARVE_MAX=4) is driven with directed requests; each
// expected completion is queued when the request is applied and a separate
// monitor pops and compares on every valid pulse. Four further instances
// (MEM_LAT=1..4) share a fetch-only requester for the reset-in-flight and
// latency sweep scenarios, each with its own monitor.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall;

   logic        sw_if_req;
   logic [31:0] sw_if_addr;
   logic        sweep_on;

   int errors      = 0;
   int checks      = 0;
   int cyc         = 0;
   int valid_seen  = 0;

   typedef struct {
      logic        is_data;
      logic        check_data;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents: 0x100 holds a NOP-like 0x13, everything else returns
   // 0xC0DE in the upper half and the low address bits in the lower half.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0013;
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dr,
                                input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd);
      if_req  = ifr;
      if_addr = ifa;
      d_req   = dr;
      d_we    = dwe;
      d_addr  = da;
      d_wdata = dwd;
   endtask

   task automatic pushExp(input logic is_data, input logic check_data, input logic [31:0] rdata);
      exp_t e;
      e.is_data    = is_data;
      e.check_data = check_data;
      e.rdata      = rdata;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitValids(input int n);
      int target;
      int budget;
      target = valid_seen + n;
      budget = 0;
      while (valid_seen < target && budget < 80) begin
         @(posedge clk);
         budget++;
      end
      #1;
      if (valid_seen < target) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_valids: got %0d completions, expected %0d within budget", valid_seen, target);
      end
   endtask

   mem_port_arbiter #(
      .MEM_LAT    (1),
      .STARVE_MAX (4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall     (stall)
   );

   // One-cycle memory for the main DUT.
   logic [31:0] m_pipe;
   always @(posedge clk) m_pipe <= mem_val(mem_addr);
   assign mem_rdata = m_pipe;

   // Scoreboard monitor for the main DUT.
   always @(negedge clk) begin : main_mon
      exp_t e;
      if (!rst && (if_valid || d_valid)) begin
         valid_seen++;
         checkOutput("valid_onehot", 32'(if_valid & d_valid), 32'h0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: got if_valid=%0b d_valid=%0b, expected no completion", if_valid, d_valid);
         end else begin
            e = exp_q.pop_front();
            checkOutput("grant_kind", 32'(d_valid), 32'(e.is_data));
            if (e.check_data) begin
               if (e.is_data) checkOutput("d_rdata", d_rdata, e.rdata);
               else           checkOutput("if_rdata", if_rdata, e.rdata);
            end
         end
      end
   end

   // Fetch-only instances for reset-in-flight and latency sweep.
   for (genvar k = 0; k < 4; k++) begin : g_sw
      localparam int LAT = k + 1;
      logic [31:0] if_rdata_k;
      logic [31:0] d_rdata_k;
      logic [31:0] mem_addr_k;
      logic [31:0] mem_wdata_k;
      logic [31:0] mem_rdata_k;
      logic [3:0]  mem_we_k;
      logic        if_valid;
      logic        d_valid;
      logic        mem_en;
      logic        stall;
      logic [31:0] pipe [LAT];
      int          last_cyc = -1;
      int          pulses   = 0;

      mem_port_arbiter #(
         .MEM_LAT    (LAT),
         .STARVE_MAX (4)
      ) u_sw (
         .clk       (clk),
         .rst       (rst),
         .if_req    (sw_if_req),
         .if_addr   (sw_if_addr),
         .if_rdata  (if_rdata_k),
         .if_valid  (if_valid),
         .d_req     (1'b0),
         .d_we      (4'b0000),
         .d_addr    (32'h0),
         .d_wdata   (32'h0),
         .d_rdata   (d_rdata_k),
         .d_valid   (d_valid),
         .mem_en    (mem_en),
         .mem_we    (mem_we_k),
         .mem_addr  (mem_addr_k),
         .mem_wdata (mem_wdata_k),
         .mem_rdata (mem_rdata_k),
         .stall     (stall)
      );

      always @(posedge clk) begin
         pipe[0] <= mem_val(mem_addr_k);
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata_k = pipe[LAT-1];

      always @(negedge clk) begin
         if (rst || !sweep_on) last_cyc = -1;
         if (!rst) begin
            checkOutput($sformatf("lat%0d_stall", LAT), 32'(stall), 32'(sw_if_req & ~if_valid));
            if (mem_en) begin
               checkOutput($sformatf("lat%0d_mem_addr", LAT), mem_addr_k, sw_if_addr);
               checkOutput($sformatf("lat%0d_mem_we", LAT), 32'(mem_we_k), 32'h0);
            end
            if (d_valid) checkOutput($sformatf("lat%0d_d_valid", LAT), 32'(d_valid), 32'h0);
            if (if_valid) begin
               checkOutput($sformatf("lat%0d_if_rdata", LAT), if_rdata_k, mem_val(sw_if_addr));
               if (sweep_on) begin
                  if (last_cyc >= 0)
                     checkOutput($sformatf("lat%0d_spacing", LAT), 32'(cyc - last_cyc), 32'(LAT + 1));
                  last_cyc = cyc;
                  pulses++;
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset with a store request held high: no command may reach the port.
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h2000, 32'h1);
      sw_if_req  = 1'b0;
      sw_if_addr = 32'h0;
      sweep_on   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_mem_en",   32'(mem_en),   32'h0);
      checkOutput("rst_mem_we",   32'(mem_we),   32'h0);
      checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
      checkOutput("rst_d_valid",  32'(d_valid),  32'h0);
      checkOutput("rst_if_rdata", if_rdata,      32'h0);
      checkOutput("rst_d_rdata",  d_rdata,       32'h0);
      checkOutput("rst_stall_req", 32'(stall),   32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      #1;
      checkOutput("rst_stall_idle", 32'(stall), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      tick();

      // Fetch only.
      $display("[TB] fetch only");
      applyStimulus(1'b1, 32'h100, 1'b0, 4'b0000, 32'h0, 32'h0);
      pushExp(1'b0, 1'b1, 32'h0000_0013);
      @(negedge clk);
      checkOutput("f_c0_mem_en",   32'(mem_en), 32'h1);
      checkOutput("f_c0_mem_addr", mem_addr,    32'h100);
      checkOutput("f_c0_mem_we",   32'(mem_we), 32'h0);
      checkOutput("f_c0_stall",    32'(stall),  32'h1);
      tick();
      @(negedge clk);
      checkOutput("f_c1_stall",    32'(stall),  32'h0);
      checkOutput("f_c1_mem_en",   32'(mem_en), 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      tick();

      // Simultaneous fetch and load: data first, then fetch.
      $display("[TB] simultaneous requests");
      applyStimulus(1'b1, 32'h300, 1'b1, 4'b0000, 32'h2000, 32'h0);
      pushExp(1'b1, 1'b1, 32'hC0DE_2000);
      pushExp(1'b0, 1'b1, 32'hC0DE_0300);
      @(negedge clk);
      checkOutput("s_c0_mem_en",   32'(mem_en), 32'h1);
      checkOutput("s_c0_mem_addr", mem_addr,    32'h2000);
      checkOutput("s_c0_stall",    32'(stall),  32'h1);
      tick();
      @(negedge clk);
      checkOutput("s_c1_stall",    32'(stall),  32'h1);
      checkOutput("s_c1_mem_en",   32'(mem_en), 32'h0);
      tick();
      applyStimulus(1'b1, 32'h300, 1'b0, 4'b0000, 32'h2000, 32'h0);
      @(negedge clk);
      checkOutput("s_c2_mem_en",   32'(mem_en), 32'h1);
      checkOutput("s_c2_mem_addr", mem_addr,    32'h300);
      checkOutput("s_c2_stall",    32'(stall),  32'h1);
      tick();
      @(negedge clk);
      checkOutput("s_c3_stall",    32'(stall),  32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      tick();

      // Store: write mask only in the issue cycle.
      $display("[TB] store");
      applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h2004, 32'hDEAD_BEEF);
      pushExp(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("st_c0_mem_en",    32'(mem_en), 32'h1);
      checkOutput("st_c0_mem_we",    32'(mem_we), 32'h3);
      checkOutput("st_c0_mem_addr",  mem_addr,    32'h2004);
      checkOutput("st_c0_mem_wdata", mem_wdata,   32'hDEAD_BEEF);
      tick();
      @(negedge clk);
      checkOutput("st_c1_mem_we",    32'(mem_we), 32'h0);
      checkOutput("st_c1_mem_en",    32'(mem_en), 32'h0);
      checkOutput("st_c1_stall",     32'(stall),  32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      tick();

      // Starvation: D,D,D,D,F,D,D,D,D,F.
      $display("[TB] starvation");
      applyStimulus(1'b1, 32'h400, 1'b1, 4'b0000, 32'h2008, 32'h0);
      for (int r = 0; r < 2; r++) begin
         for (int j = 0; j < 4; j++) pushExp(1'b1, 1'b1, 32'hC0DE_2008);
         pushExp(1'b0, 1'b1, 32'hC0DE_0400);
      end
      waitValids(10);
      applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      repeat (4) tick();
      checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);

      // Reset while a MEM_LAT=3 fetch is in flight.
      $display("[TB] reset mid-transaction");
      tick();
      sw_if_addr = 32'h500;
      sw_if_req  = 1'b1;
      @(negedge clk);
      checkOutput("rt_issue_en",   32'(g_sw[2].mem_en), 32'h1);
      checkOutput("rt_issue_addr", g_sw[2].mem_addr_k,  32'h500);
      tick();
      #1 rst = 1'b1;
      #1;
      checkOutput("rt_mem_en",   32'(g_sw[2].mem_en),   32'h0);
      checkOutput("rt_if_valid", 32'(g_sw[2].if_valid), 32'h0);
      checkOutput("rt_d_valid",  32'(g_sw[2].d_valid),  32'h0);
      checkOutput("rt_stall",    32'(g_sw[2].stall),    32'h1);
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rt_reissue_en", 32'(g_sw[2].mem_en),   32'h1);
      checkOutput("rt_no_valid",   32'(g_sw[2].if_valid), 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge clk);
         checkOutput("rt_no_valid", 32'(g_sw[2].if_valid), 32'h0);
      end
      tick();
      @(negedge clk);
      checkOutput("rt_new_valid", 32'(g_sw[2].if_valid), 32'h1);
      tick();
      sw_if_req = 1'b0;
      repeat (6) tick();

      // Latency sweep: back-to-back fetches for 40 cycles.
      $display("[TB] latency sweep");
      sweep_on   = 1'b1;
      sw_if_addr = 32'h600;
      sw_if_req  = 1'b1;
      repeat (40) tick();
      sw_if_req = 1'b0;
      repeat (8) tick();
      sweep_on = 1'b0;
      checkOutput("lat1_pulses", 32'(g_sw[0].pulses), 32'd20);
      checkOutput("lat2_pulses", 32'(g_sw[1].pulses), 32'd14);
      checkOutput("lat3_pulses", 32'(g_sw[2].pulses), 32'd10);
      checkOutput("lat4_pulses", 32'(g_sw[3].pulses), 32'd8);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
